cmp_iter: RTL and testbench
===========================

// Module: cmp_iter
// PURPOSE
//  Multi-cycle branch comparator. Generalises the single-cycle cmp to WIDTH-bit operands.
//  Evaluates CHUNK bits per clock, MSB chunk first, under a valid/ready handshake.
//  Sits between operand fetch and branch resolution in area-constrained cores.
//  Shares the cmpop.svh encoding: BEQ, BNE, BLT, BGE, BLTU, BGEU.
// PARAMETERS
//  WIDTH  32  operand width in bits
//  CHUNK  8   bits compared per cycle; WIDTH % CHUNK must be 0 (elaboration $error otherwise)
//  NCHUNK = WIDTH/CHUNK (localparam); NCHUNK==1 is legal
// PORTS
//  i_clk    in   1      clock, rising edge
//  i_rst_n  in   1      asynchronous reset, active low
//  i_valid  in   1      request valid
//  o_ready  out  1      request accepted when i_valid && o_ready
//  i_a      in   WIDTH  operand A, sampled at accept
//  i_b      in   WIDTH  operand B, sampled at accept
//  i_cmpop  in   3      compare op (cmpop.svh), sampled at accept
//  o_valid  out  1      result valid; held until taken
//  i_ready  in   1      consumer ready; result retires when o_valid && i_ready
//  o_taken  out  1      branch decision; 0 whenever o_valid==0
// BEHAVIOUR
//  Reset (async, i_rst_n==0): state=IDLE, o_valid=0, o_taken=0, chunk counter=0, flags cleared.
//  o_ready = (state==IDLE), so it reads 1 after reset.
//  FSM states:
//   - IDLE: on accept, latch a/b/op; chunk idx=NCHUNK-1; clear decided/lt; go to BUSY.
//   - BUSY: compare chunk idx of a vs b unsigned.
//     - For BLT/BGE, invert the WIDTH-1 bit of both operands first (signed->unsigned mapping).
//     - If !decided and chunks differ: decided=1, lt=(a_chunk<b_chunk).
//     - When idx==0 (last chunk), go to DONE; otherwise idx--.
//   - DONE: o_valid=1, o_taken registered; on i_ready go to IDLE, clear o_valid/o_taken.
//  Result mapping: eq=!decided.
//   - BEQ eq; BNE !eq; BLT/BLTU lt; BGE/BGEU !lt.
//   - Undefined cmpop codes give o_taken=0 and the normal latency.
//  Latency: accept edge E0; o_valid rises after edge E0+NCHUNK.
//  Throughput: one op per NCHUNK+2 cycles when i_ready is held high.
//  o_ready=0 in BUSY/DONE; i_valid there is ignored, not queued.
//  Input changes after accept have no effect.
//  Backpressure: in DONE with i_ready=0, o_valid and o_taken are held stable indefinitely.
//  Reset mid-operation: aborts the op immediately; no o_valid pulse; IDLE after release.
//  Equal operands never set decided; every chunk is scanned.
// CONFIGURATION
//  CMP_EARLY_EXIT_EN defined:
//   - BUSY transitions to DONE on the edge where decided first sets.
//   - o_valid rises after edge E0+k+1, where k = position (from MSB, 0-based) of the first differing chunk.
//   - Equal operands still take NCHUNK cycles.
//  Undefined: fixed NCHUNK latency for all operands (constant-time).
//  o_taken values are identical in both builds.
// TESTING (WIDTH=32, CHUNK=8)
//  BEQ a=3 b=3 -> o_taken=1; o_valid after E0+4 in both builds.
//  BLT a=-5 b=3 -> o_taken=1; EARLY_EXIT: o_valid after E0+1; else after E0+4.
//  BLTU a=-5 b=3 -> o_taken=0; BGEU with the same operands -> o_taken=1.
//  BGE a=-3 b=-5 -> o_taken=1; difference is in LSB chunk, so E0+4 in both builds.
//  Also: cmpop=3'b010 -> o_taken=0.
//  Backpressure: i_ready=0 for 5 cycles in DONE -> o_valid=1 and o_taken stable, o_ready=0.
//   - i_valid pulses during that window are ignored.
//   - Next accepted op is correct.
//  Reset: drop i_rst_n during the 2nd BUSY cycle -> o_valid=0, o_taken=0, o_ready=1 after release.
//   - Then BNE a=5 b=3 -> o_taken=1.

Source files
------------

// File: rtl/cmp_iter.sv
// rtl/cmp_iter.sv - Multi-cycle chunked branch comparator with valid/ready handshake
//
// Compares two WIDTH-bit operands CHUNK bits per clock, most significant chunk
// first, and reports the branch decision for the latched compare op.
//
// Compare op encoding (cmpop.svh):
//   000 BEQ, 001 BNE, 100 BLT, 101 BGE, 110 BLTU, 111BGEU. All other codes give taken=0.
//
// Optional build macro:
//   CMP_EARLY_EXIT_EN - finish on the first differing chunk instead of always
//                       scanning all NCHUNK chunks. The decision is the same
//                       either way; only the latency changes.
//
// Ports:
//   i_clk, i_rst_n   clock (rising edge), asynchronous active-low reset
//   i_valid/o_ready  request handshake; i_a, i_b, i_cmpop sampled at accept
//   o_valid/i_ready  result handshake; o_valid held until i_ready
//   o_taken          branch decision, 0 whenever o_valid is 0
module cmp_iter #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic [2:0]       i_cmpop,
    output logic             o_valid,
    input  logic             i_ready,
    output logic             o_taken
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NCHUNK - 1);

    generate
        if (WIDTH % CHUNK != 0) begin : g_bad_chunk
            $error("cmp_iter: WIDTH must be a multiple of CHUNK");
        end
    endgenerate

    localparam logic [2:0] OP_BEQ  = 3'b000;
    localparam logic [2:0] OP_BNE  = 3'b001;
    localparam logic [2:0] OP_BLT  = 3'b100;
    localparam logic [2:0] OP_BGE  = 3'b101;
    localparam logic [2:0] OP_BLTU = 3'b110;
    localparam logic [2:0] OP_BGEU = 3'b111;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       state;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [2:0]       op_q;
    logic [IDXW-1:0]  idx;
    logic             decided;
    logic             lt;

    logic [CHUNK-1:0] a_ch;
    logic [CHUNK-1:0] b_ch;
    logic             differ;
    logic             decided_n;
    logic             lt_n;
    logic             go_done;
    logic             taken_n;
    logic [WIDTH-1:0] sign_flip;

    assign o_ready = (state == S_IDLE);

    // Flipping the sign bit maps two's-complement order onto unsigned order,
    // so the chunk scan itself is always unsigned.
    assign sign_flip = (i_cmpop == OP_BLT || i_cmpop == OP_BGE)
                       ? {1'b1, {(WIDTH-1){1'b0}}} : '0;

    always_comb begin
        a_ch      = a_q[idx*CHUNK +: CHUNK];
        b_ch      = b_q[idx*CHUNK +: CHUNK];
        differ    = (a_ch != b_ch);
        // Only the first (most significant) differing chunk decides the order.
        decided_n = decided | differ;
        lt_n      = decided ? lt : (a_ch < b_ch);
`ifdef CMP_EARLY_EXIT_EN
        go_done   = (idx == '0) || (!decided && differ);
`else
        go_done   = (idx == '0);
`endif
        case (op_q)
            OP_BEQ:           taken_n = !decided_n;
            OP_BNE:           taken_n = decided_n;
            OP_BLT, OP_BLTU:  taken_n = lt_n;
            OP_BGE, OP_BGEU:  taken_n = !lt_n;
            default:          taken_n = 1'b0;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state   <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= '0;
            idx     <= '0;
            decided <= 1'b0;
            lt      <= 1'b0;
            o_valid <= 1'b0;
            o_taken <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (i_valid) begin
                        a_q     <= i_a ^ sign_flip;
                        b_q     <= i_b ^ sign_flip;
                        op_q    <= i_cmpop;
                        idx     <= LAST_IDX;
                        decided <= 1'b0;
                        lt      <= 1'b0;
                        state   <= S_BUSY;
                    end
                end
                S_BUSY: begin
                    decided <= decided_n;
                    lt      <= lt_n;
                    if (go_done) begin
                        state   <= S_DONE;
                        o_valid <= 1'b1;
                        o_taken <= taken_n;
                    end else begin
                        idx <= idx - 1'b1;
                    end
                end
                S_DONE: begin
                    if (i_ready) begin
                        state   <= S_IDLE;
                        o_valid <= 1'b0;
                        o_taken <= 1'b0;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cmp_iter.sv
// tb/tb_cmp_iter.sv - Directed self-checking bench for cmp_iter (WIDTH=32, CHUNK=8)
module tb_cmp_iter;

    localparam int WIDTH = 32;
    localparam int CHUNK = 8;
`ifdef CMP_EARLY_EXIT_EN
    localparam int EARLY = 1;
`else
    localparam int EARLY = 0;
`endif
    localparam int LAT_FULL = 4;
    localparam int LAT_MSB  = EARLY ? 1 : 4;

    localparam logic [2:0] BEQ  = 3'b000;
    localparam logic [2:0] BNE  = 3'b001;
    localparam logic [2:0] BLT  = 3'b100;
    localparam logic [2:0] BGE  = 3'b101;
    localparam logic [2:0] BLTU = 3'b110;
    localparam logic [2:0] BGEU = 3'b111;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             out_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [2:0]       cmpop;
    logic             out_valid;
    logic             in_ready;
    logic             taken;

    int n_checks = 0;
    int n_fail   = 0;

    cmp_iter #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_valid (in_valid),
        .o_ready (out_ready),
        .i_a     (a),
        .i_b     (b),
        .i_cmpop (cmpop),
        .o_valid (out_valid),
        .i_ready (in_ready),
        .o_taken (taken)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Issue one op, scramble the inputs after accept, and report the number of
    // edges from accept to o_valid (99 on timeout) plus the decision seen.
    task automatic do_op(input logic [WIDTH-1:0] va, input logic [WIDTH-1:0] vb,
                         input logic [2:0] op, output int lat, output logic tk);
        @(negedge clk);
        a = va; b = vb; cmpop = op; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        a = $urandom; b = $urandom; cmpop = 3'($urandom);
        lat = 99;
        tk  = 1'bx;
        for (int c = 1; c <= 20; c++) begin
            if (out_valid) begin
                lat = c - 1;
                tk  = taken;
                break;
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; in_ready = 1'b1; a = '0; b = '0; cmpop = '0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (out_valid !== 1'b0 || taken !== 1'b0 || out_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_outputs: got valid=%b taken=%b ready=%b expected 0 0 1",
                     out_valid, taken, out_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        n_checks++;
        if (out_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_release: got ready=%b valid=%b expected 1 0", out_ready, out_valid);
        end
    endtask

    task automatic test_op(input string name, input logic [WIDTH-1:0] va,
                           input logic [WIDTH-1:0] vb, input logic [2:0] op,
                           input logic exp_tk, input int exp_lat);
        int lat;
        logic tk;
        do_op(va, vb, op, lat, tk);
        n_checks++;
        if (tk !== exp_tk) begin
            n_fail++;
            $display("FAIL %s_taken: got %b expected %b", name, tk, exp_tk);
        end
        n_checks++;
        if (lat != exp_lat) begin
            n_fail++;
            $display("FAIL %s_latency: got %0d expected %0d", name, lat, exp_lat);
        end
        @(posedge clk);
        #1;
        n_checks++;
        if (out_valid !== 1'b0 || taken !== 1'b0 || out_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL %s_retire: got valid=%b taken=%b ready=%b expected 0 0 1",
                     name, out_valid, taken, out_ready);
        end
    endtask

    task automatic test_backpressure();
        int lat;
        logic tk;
        in_ready = 1'b0;
        do_op(32'hFFFF_FFFB, 32'd3, BLT, lat, tk);
        n_checks++;
        if (tk !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_taken: got %b expected 1", tk);
        end
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            in_valid = c[0];
            a = 32'hFFFF_FFFB; b = 32'd3; cmpop = BLTU;
            @(posedge clk);
            #1;
            n_checks++;
            if (out_valid !== 1'b1 || taken !== 1'b1 || out_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL bp_hold[%0d]: got valid=%b taken=%b ready=%b expected 1 1 0",
                         c, out_valid, taken, out_ready);
            end
        end
        @(negedge clk);
        in_valid = 1'b0;
        in_ready = 1'b1;
        @(posedge clk);
        #1;
        n_checks++;
        if (out_valid !== 1'b0 || out_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_release: got valid=%b ready=%b expected 0 1", out_valid, out_ready);
        end
        test_op("bp_next", 32'hFFFF_FFFB, 32'd3, BLTU, 1'b0, LAT_MSB);
    endtask

    task automatic test_reset_mid();
        bit pulsed;
        @(negedge clk);
        a = 32'd3; b = 32'd3; cmpop = BEQ; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (out_valid !== 1'b0 || taken !== 1'b0 || out_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_mid_async: got valid=%b taken=%b ready=%b expected 0 0 1",
                     out_valid, taken, out_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
        pulsed = 1'b0;
        for (int c = 0; c < 8; c++) begin
            @(posedge clk);
            #1;
            if (out_valid !== 1'b0 || out_ready !== 1'b1) pulsed = 1'b1;
        end
        n_checks++;
        if (pulsed) begin
            n_fail++;
            $display("FAIL rst_mid_quiet: got a valid pulse or busy state after release, expected idle");
        end
        test_op("rst_bne", 32'd5, 32'd3, BNE, 1'b1, LAT_FULL);
    endtask

    task automatic test_back_to_back();
        int acc[$];
        @(negedge clk);
        a = 32'd7; b = 32'd7; cmpop = BEQ; in_valid = 1'b1; in_ready = 1'b1;
        for (int c = 0; c < 14; c++) begin
            if (out_ready) acc.push_back(c);
            @(negedge clk);
        end
        in_valid = 1'b0;
        n_checks++;
        if (acc.size() < 2) begin
            n_fail++;
            $display("FAIL b2b_count: got %0d accepts expected at least 2", acc.size());
        end else if (acc[1] - acc[0] != LAT_FULL + 2) begin
            n_fail++;
            $display("FAIL b2b_interval: got %0d cycles expected %0d", acc[1] - acc[0], LAT_FULL + 2);
        end
        repeat (10) @(posedge clk);
        #1;
    endtask

    initial begin
        test_reset();
        test_op("beq",   32'd3,         32'd3,         BEQ,    1'b1, LAT_FULL);
        test_op("blt",   32'hFFFF_FFFB, 32'd3,         BLT,    1'b1, LAT_MSB);
        test_op("bltu",  32'hFFFF_FFFB, 32'd3,         BLTU,   1'b0, LAT_MSB);
        test_op("bgeu",  32'hFFFF_FFFB, 32'd3,         BGEU,   1'b1, LAT_MSB);
        test_op("bge",   32'hFFFF_FFFD, 32'hFFFF_FFFB, BGE,    1'b1, LAT_FULL);
        test_op("bne_eq", 32'h1234_5678, 32'h1234_5678, BNE,   1'b0, LAT_FULL);
        test_op("bge_lt", 32'h8000_0000, 32'h0000_0001, BGE,   1'b0, LAT_MSB);
        test_op("undef", 32'd3,         32'd3,         3'b010, 1'b0, LAT_FULL);
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
